// File: rtl/uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// uart_tx_cfg -- configurable UART transmitter with a small transmit queue.
//
// Frames each queued word as: start bit (0), DATA_BITS data bits LSB first,
// an optional parity bit (even or odd), then STOP_BITS stop bits (1). Each
// bit is held on the line for CLKS_PER_BIT clock cycles. Frames are sent
// back-to-back while the queue holds words.
//
// Ports
//   clk        : single clock, all logic on its rising edge
//   rst        : synchronous active-high reset
//   tx_valid   : a word is offered on data_in
//   data_in    : the word to send (DATA_BITS wide)
//   tx_ready   : the queue can accept a word (queue not full)
//   tx         : registered serial line, idles high
//   busy       : registered; a frame is in progress or the queue is non-empty
//   fifo_count : number of words waiting in the queue
// ---------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam logic [CW-1:0] CNT_LAST       = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    IDX_STOP_LAST  = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   COUNT_FULL     = (AW+1)'(FIFO_DEPTH);

    // Transmit queue
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    // Frame engine
    logic [2:0]           r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [2:0]           r_bit_idx;   // data bit index in DATA, stop bit index in STOP
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;

    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_next_idle;
    logic [AW:0]          w_count_next;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    assign tx_ready   = (r_count != COUNT_FULL);
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;

    assign w_bit_end   = (r_clk_cnt == CNT_LAST);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bit_idx == IDX_STOP_LAST);
    assign w_empty     = (r_count == '0);
    assign w_push      = tx_valid && tx_ready;
    // The head word leaves the queue when a new frame starts: from idle, or
    // on the edge that ends the last stop bit (back-to-back frames).
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || w_frame_end);
    assign w_next_idle = w_empty && ((r_state == S_IDLE) || w_frame_end);

    // The head is read combinationally so a frame can start on the very edge
    // the word is popped; the queue is small enough for distributed storage.
    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_par  = (PARITY == 2) ? ~(^w_head) : (^w_head);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + (AW+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - (AW+1)'(1);
        end
    end

    // Queue storage has no reset; only the pointers and count define content.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_busy  <= !w_next_idle || (w_count_next != '0);

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_clk_cnt <= '0;
                        r_shift   <= w_head;
                        r_par     <= w_head_par;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == IDX_DATA_LAST) begin
                            r_bit_idx <= '0;
                            if (PARITY != 0) begin
                                r_state <= S_PAR;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_STOP;
                        r_tx      <= 1'b1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == IDX_STOP_LAST) begin
                            r_bit_idx <= '0;
                            if (w_pop) begin
                                // Next frame starts with no idle gap.
                                r_state <= S_START;
                                r_tx    <= 1'b0;
                                r_shift <= w_head;
                                r_par   <= w_head_par;
                            end else begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_cfg -- self-checking bench for uart_tx_cfg.
//
// Three instances share one clock: 8N1, 7E2 and 8O1, all with 4 clocks per
// bit and a 4-entry queue. A reference model keeps, per instance, a plain
// array of queued words and the expanded per-cycle line pattern of the frame
// being sent; tx, busy, fifo_count and tx_ready are compared every cycle on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_cfg;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_r;
    logic [2:0] valid_r;
    logic [7:0] din_a [3];
    logic [2:0] tx_w;
    logic [2:0] busy_w;
    logic [2:0] rdy_w;
    logic [2:0] cnt0, cnt1, cnt2;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .clk(clk), .rst(rst_r[0]), .tx_valid(valid_r[0]), .data_in(din_a[0]),
        .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(cnt0));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7e2 (
        .clk(clk), .rst(rst_r[1]), .tx_valid(valid_r[1]), .data_in(din_a[1][6:0]),
        .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(cnt1));

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
        .clk(clk), .rst(rst_r[2]), .tx_valid(valid_r[2]), .data_in(din_a[2]),
        .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(cnt2));

    // Reference model state
    logic [7:0] qbuf [3][16];
    int         qn   [3];
    logic       line [3][64];
    int         lpos [3];
    int         llen [3];

    int n_pass  = 0;
    int n_total = 0;

    function automatic int db_of(input int k);
        return (k == 1) ? 7 : 8;
    endfunction

    function automatic int par_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 2);
    endfunction

    function automatic int sb_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    // Expand one word into its per-cycle line pattern.
    task automatic build_frame(input int k, input logic [7:0] w);
        logic [15:0] bits;
        int          nb;
        logic        p;
        bits = '0;
        nb   = 0;
        p    = 1'b0;
        bits[nb] = 1'b0;
        nb = nb + 1;
        for (int i = 0; i < db_of(k); i++) begin
            bits[nb] = w[i];
            p = p ^ w[i];
            nb = nb + 1;
        end
        if (par_of(k) != 0) begin
            bits[nb] = (par_of(k) == 2) ? ~p : p;
            nb = nb + 1;
        end
        for (int s = 0; s < sb_of(k); s++) begin
            bits[nb] = 1'b1;
            nb = nb + 1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                line[k][b*CPB + c] = bits[b];
            end
        end
        llen[k] = nb * CPB;
        lpos[k] = 0;
    endtask

    // Advance instance k's model by one rising edge.
    task automatic model_edge(input int k);
        int   old_n;
        logic acc;
        old_n = qn[k];
        if (rst_r[k]) begin
            qn[k]   = 0;
            llen[k] = 0;
            lpos[k] = 0;
        end else begin
            acc = valid_r[k] && (old_n != DEPTH);
            if (lpos[k] < llen[k]) lpos[k] = lpos[k] + 1;
            if ((lpos[k] >= llen[k]) && (old_n > 0)) begin
                build_frame(k, qbuf[k][0]);
                for (int j = 0; j < 15; j++) qbuf[k][j] = qbuf[k][j+1];
                qn[k] = qn[k] - 1;
            end
            if (acc) begin
                qbuf[k][qn[k]] = (k == 1) ? (din_a[k] & 8'h7F) : din_a[k];
                qn[k] = qn[k] + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s inst%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
            $error("%s inst%0d observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_inst(input int k);
        logic [7:0] cnt_obs;
        logic       exp_tx;
        case (k)
            0:       cnt_obs = {5'd0, cnt0};
            1:       cnt_obs = {5'd0, cnt1};
            default: cnt_obs = {5'd0, cnt2};
        endcase
        exp_tx = (lpos[k] < llen[k]) ? line[k][lpos[k]] : 1'b1;
        chk("tx",         k, {7'd0, tx_w[k]},   {7'd0, exp_tx});
        chk("busy",       k, {7'd0, busy_w[k]}, {7'd0, ((lpos[k] < llen[k]) || (qn[k] > 0))});
        chk("fifo_count", k, cnt_obs,           8'(qn[k]));
        chk("tx_ready",   k, {7'd0, rdy_w[k]},  {7'd0, (qn[k] != DEPTH)});
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_inst(k);
    endtask

    initial begin
        logic [7:0] wl [6];
        int         idx;
        int         guard;
        logic       acc;

        wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h3C;
        wl[3] = 8'hC3; wl[4] = 8'hA0; wl[5] = 8'h0F;
        for (int k = 0; k < 3; k++) begin
            qn[k] = 0; lpos[k] = 0; llen[k] = 0; din_a[k] = 8'h00;
        end
        rst_r   = 3'b111;
        valid_r = 3'b000;
        tick();
        tick();
        rst_r = 3'b000;
        tick();

        // Single frames: 0x55 on 8N1, 0x03 on 7E2, 0x00 then 0x01 on 8O1
        valid_r  = 3'b111;
        din_a[0] = 8'h55;
        din_a[1] = 8'h03;
        din_a[2] = 8'h00;
        tick();
        valid_r = 3'b000;
        repeat (50) tick();
        valid_r[2] = 1'b1;
        din_a[2]   = 8'h01;
        tick();
        valid_r = 3'b000;
        repeat (45) tick();

        // Six words offered continuously; advance only when the model accepts
        idx   = 0;
        guard = 0;
        while (idx < 6 && guard < 400) begin
            din_a[0]   = wl[idx];
            valid_r[0] = 1'b1;
            acc = (qn[0] != DEPTH);
            tick();
            if (acc) idx++;
            guard++;
        end
        valid_r[0] = 1'b0;
        if (idx != 6) begin
            n_total++;
            $display("FAIL push6_timeout inst0 observed=%0d words expected=6", idx);
        end
        repeat (260) tick();

        // Two queued, reset during data bit 3, then 0xA5
        valid_r[0] = 1'b1;
        din_a[0]   = 8'h9E;
        tick();
        din_a[0]   = 8'h47;
        tick();
        valid_r[0] = 1'b0;
        repeat (16) tick();
        rst_r[0] = 1'b1;
        tick();
        rst_r[0]   = 1'b0;
        valid_r[0] = 1'b1;
        din_a[0]   = 8'hA5;
        tick();
        valid_r[0] = 1'b0;
        repeat (45) tick();

        // Count of 2 with push and pop on the same edge
        valid_r[0] = 1'b1;
        din_a[0] = 8'h12; tick();
        din_a[0] = 8'h34; tick();
        din_a[0] = 8'h56; tick();
        valid_r[0] = 1'b0;
        repeat (38) tick();
        valid_r[0] = 1'b1;
        din_a[0]   = 8'h78;
        tick();
        valid_r[0] = 1'b0;
        repeat (130) tick();

        // Random traffic with rare resets
        repeat (800) begin
            for (int k = 0; k < 3; k++) begin
                valid_r[k] = ($urandom_range(0, 2) == 0);
                din_a[k]   = 8'($urandom);
                rst_r[k]   = ($urandom_range(0, 399) == 0);
            end
            tick();
        end
        valid_r = 3'b000;
        rst_r   = 3'b000;
        repeat (200) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL expose parameter CLKS_PER_BIT, default 1250: clock cycles per serial bit; legal range >= 2.
REQ-002 SHALL expose parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 SHALL expose parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL expose parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 SHALL expose parameter FIFO_DEPTH, default 4: transmit queue entries; power of 2, >= 2.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL provide port tx_valid, input, 1 bit: a word is offered on data_in.
REQ-009 SHALL provide port data_in, input, DATA_BITS bits: the word to send.
REQ-010 SHALL provide port tx_ready, output, 1 bit: the queue can accept a word.
REQ-011 SHALL provide port tx, output, 1 bit: the registered serial line; idles high.
REQ-012 SHALL provide port busy, output, 1 bit: a frame is in progress or the queue is non-empty.
REQ-013 SHALL provide port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of queued words.

Function
REQ-014 A word SHALL be accepted on an edge where tx_valid and tx_ready are both 1, and only on such an edge.
REQ-015 tx_ready SHALL equal (fifo_count != FIFO_DEPTH); a pop on the same edge SHALL NOT make a full queue accept a word.
REQ-016 A simultaneous push and pop with a non-full queue SHALL leave fifo_count unchanged, with FIFO ordering preserved.
REQ-017 The FSM SHALL have the states IDLE, START, DATA, PAR and STOP.
REQ-018 In IDLE with a non-empty queue, the FSM SHALL pop the head word, move to START and drive tx=0 on the same edge.
REQ-019 A word pushed into an empty queue while idle SHALL cause tx to fall 1 cycle after the accepting edge.
REQ-020 Every bit SHALL be held on tx for exactly CLKS_PER_BIT cycles, counted by a bit-period counter that is cleared at each bit boundary.
REQ-021 DATA SHALL send DATA_BITS bits, LSB first.
REQ-022 PAR SHALL be entered only when PARITY != 0.
REQ-023 The even-parity bit SHALL be the XOR of the data bits; the odd-parity bit SHALL be its inverse.
REQ-024 STOP SHALL drive tx=1 for STOP_BITS bit periods.
REQ-025 A frame SHALL be 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods long.
REQ-026 At the end of the last stop period, if the queue is non-empty, the next START SHALL begin on the same edge, with zero idle cycles between frames.
REQ-027 At the end of the last stop period, if the queue is empty, the FSM SHALL go to IDLE with tx=1.
REQ-028 busy SHALL be registered and SHALL be 1 whenever state != IDLE or fifo_count != 0.
REQ-029 Bit-index and period counters SHALL wrap or clear only at frame or bit boundaries; no partial bit period SHALL ever be emitted.
REQ-030 tx_valid and data_in SHALL have no effect on the frame currently being shifted out.

Reset
REQ-031 On any edge with rst=1, the block SHALL set tx=1, busy=0, fifo_count=0, tx_ready=1 and state=IDLE, and SHALL clear all counters.
REQ-032 Reset asserted mid-frame SHALL abort that frame and discard all queued words; tx SHALL be high after that edge.
REQ-033 tx_valid SHALL be ignored on any edge where rst=1.
REQ-034 The first word accepted after rst deasserts SHALL be framed correctly from its start bit.

Verification (bench: CLKS_PER_BIT=4)
REQ-035 8N1, push 0x55 while idle -> tx carries 0,1,0,1,0,1,0,1,0,1, each held 4 cycles; tx falls 1 cycle after the push; busy falls after the 40th bit-cycle.
REQ-036 DATA_BITS=7, PARITY=1, STOP_BITS=2, push 0x03 -> tx carries 0, then 1,1,0,0,0,0,0, then parity 0, then 1,1; the frame lasts 44 cycles.
REQ-037 8O1, push 0x00 -> parity bit = 1; the same bench with 0x01 -> parity bit = 0.
REQ-038 FIFO_DEPTH=4, tx_valid held high with 6 distinct words -> tx_ready drops when fifo_count=4; all 6 words are sent in order, back-to-back with zero idle cycles, none lost or duplicated.
REQ-039 Two words queued, rst pulsed for 1 cycle during data bit 3 -> tx=1, busy=0 and fifo_count=0 on the next edge; a following push of 0xA5 is transmitted correctly.
REQ-040 Queue count=2 with push and pop on the same edge -> fifo_count stays 2 and output order is unchanged.
